ex_muldiv: RTL and testbench

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the EX-side operands and control (EX_Rs_data, EX_Rt_data, a decoded mult/div op) and performs MIPS mult/multu/div/divu over multiple cycles into private HI/LO registers. It raises a busy flag that the hazard unit uses to stall or flush the front end. It also serves mfhi/mflo reads.

---
 rtl/ex_muldiv.sv | 168 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Purpose  : Iterative MIPS mult/multu/div/divu unit with private HI/LO.
//            Define MD_EARLY_TERM_EN to end multiplies at the multiplier MSB.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EX_MD_Start,
    input  logic [1:0]           EX_MD_Op,
    input  logic [DATA_SIZE-1:0] EX_Rs_data,
    input  logic [DATA_SIZE-1:0] EX_Rt_data,
    input  logic                 EX_MD_Sel,
    output logic [DATA_SIZE-1:0] MD_Rd_data,
    output logic                 MD_Busy,
    output logic                 MD_Done,
    output logic                 MD_DivZero,
    output logic [DATA_SIZE-1:0] MD_HI,
    output logic [DATA_SIZE-1:0] MD_LO
);

    localparam int         c_PW   = 2 * DATA_SIZE;
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ITER = 2'd1;
    localparam logic [1:0] c_SIGN = 2'd2;
    localparam logic [5:0] c_FULL_LAST = 6'(DATA_SIZE - 1);

    logic [1:0]           r_state, w_next_state;
    logic [5:0]           r_cnt, r_last;
    logic                 r_is_div, r_neg_res, r_neg_rem, r_dz;
    logic [c_PW-1:0]      r_a, r_acc;
    logic [DATA_SIZE-1:0] r_b, r_hi, r_lo;
    logic                 r_done, r_divzero;

    logic                 w_idle, w_iter, w_sign, w_accept;
    logic                 w_is_div, w_signed, w_neg_a, w_neg_b, w_b_zero;
    logic [DATA_SIZE-1:0] w_mag_a, w_mag_b;
    logic [5:0]           w_mult_last;
    logic [DATA_SIZE:0]   w_div_shift;
    logic [DATA_SIZE+1:0] w_div_diff;
    logic                 w_div_ok;
    logic [c_PW-1:0]      w_prod;
    logic [DATA_SIZE-1:0] w_quo, w_rem;

    // Operand decode: signed ops work on magnitudes and fix the sign at the end
    assign w_is_div = EX_MD_Op[1];
    assign w_signed = ~EX_MD_Op[0];
    assign w_neg_a  = w_signed & EX_Rs_data[DATA_SIZE-1];
    assign w_neg_b  = w_signed & EX_Rt_data[DATA_SIZE-1];
    assign w_mag_a  = w_neg_a ? (~EX_Rs_data + 1'b1) : EX_Rs_data;
    assign w_mag_b  = w_neg_b ? (~EX_Rt_data + 1'b1) : EX_Rt_data;
    assign w_b_zero = (EX_Rt_data == '0);

`ifdef MD_EARLY_TERM_EN
    always_comb begin
        w_mult_last = '0;
        for (int i = 0; i < DATA_SIZE; i++) begin
            if (w_mag_b[i]) w_mult_last = 6'(i);
        end
    end
`else
    assign w_mult_last = c_FULL_LAST;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= c_IDLE;
        else      r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: if (EX_MD_Start)
                        w_next_state = (w_is_div && w_b_zero) ? c_SIGN : c_ITER;
            c_ITER: if (r_cnt == r_last) w_next_state = c_SIGN;
            c_SIGN: w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // State-derived outputs and strobes
    always_comb begin
        w_idle  = 1'b0;
        w_iter  = 1'b0;
        w_sign  = 1'b0;
        MD_Busy = 1'b1;
        case (r_state)
            c_IDLE: begin w_idle = 1'b1; MD_Busy = 1'b0; end
            c_ITER: w_iter = 1'b1;
            c_SIGN: w_sign = 1'b1;
            default: MD_Busy = 1'b0;
        endcase
    end

    assign w_accept = w_idle & EX_MD_Start;

    // Restoring divide step: remainder in r_acc low half, quotient shifts into r_a
    assign w_div_shift = {r_acc[DATA_SIZE-1:0], r_a[DATA_SIZE-1]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_b};
    assign w_div_ok    = ~w_div_diff[DATA_SIZE+1];

    assign w_prod = r_neg_res ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_neg_res ? (~r_a[DATA_SIZE-1:0] + 1'b1) : r_a[DATA_SIZE-1:0];
    assign w_rem  = r_neg_rem ? (~r_acc[DATA_SIZE-1:0] + 1'b1) : r_acc[DATA_SIZE-1:0];

    // Datapath: operand latch, iteration, and sign fix-up into HI/LO
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_done    <= w_sign;
            r_divzero <= w_sign & r_dz;
            if (w_accept) begin
                r_cnt     <= '0;
                r_is_div  <= w_is_div;
                r_neg_res <= w_neg_a ^ w_neg_b;
                r_neg_rem <= w_neg_a;
                r_dz      <= w_is_div & w_b_zero;
                r_last    <= w_is_div ? c_FULL_LAST : w_mult_last;
                r_acc     <= '0;
                r_b       <= w_mag_b;
                // Divide-by-zero reports the raw dividend in HI
                r_a       <= {{DATA_SIZE{1'b0}},
                              (w_is_div && w_b_zero) ? EX_Rs_data : w_mag_a};
            end else if (w_iter) begin
                r_cnt <= r_cnt + 6'd1;
                if (r_is_div) begin
                    r_acc[DATA_SIZE-1:0] <= w_div_ok ? w_div_diff[DATA_SIZE-1:0]
                                                     : w_div_shift[DATA_SIZE-1:0];
                    r_a[DATA_SIZE-1:0]   <= {r_a[DATA_SIZE-2:0], w_div_ok};
                end else begin
                    if (r_b[0]) r_acc <= r_acc + r_a;
                    r_a <= r_a << 1;
                    r_b <= r_b >> 1;
                end
            end else if (w_sign) begin
                if (r_dz) begin
                    r_hi <= r_a[DATA_SIZE-1:0];
                    r_lo <= '1;
                end else if (r_is_div) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end else begin
                    r_hi <= w_prod[c_PW-1:DATA_SIZE];
                    r_lo <= w_prod[DATA_SIZE-1:0];
                end
            end
        end
    end

    assign MD_HI      = r_hi;
    assign MD_LO      = r_lo;
    assign MD_Done    = r_done;
    assign MD_DivZero = r_divzero;
    assign MD_Rd_data = EX_MD_Sel ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv
// Purpose  : Self-checking bench for ex_muldiv against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        EX_MD_Start = 1'b0;
    logic [1:0]  EX_MD_Op = 2'b00;
    logic [31:0] EX_Rs_data = '0;
    logic [31:0] EX_Rt_data = '0;
    logic        EX_MD_Sel = 1'b0;
    logic [31:0] MD_Rd_data, MD_HI, MD_LO;
    logic        MD_Busy, MD_Done, MD_DivZero;

    int n_checks = 0;
    int n_errors = 0;

    // Expected architectural HI/LO, tracked from the model only
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    // Observations from the most recent run_op
    int          o_done_k, o_busy_cnt, o_drift, o_stray_dz;
    logic        o_busy_at_done, o_dz;
    logic [31:0] o_hi, o_lo;

    always #5 clk = ~clk;

    ex_muldiv #(.DATA_SIZE(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .EX_MD_Start(EX_MD_Start),
        .EX_MD_Op   (EX_MD_Op),
        .EX_Rs_data (EX_Rs_data),
        .EX_Rt_data (EX_Rt_data),
        .EX_MD_Sel  (EX_MD_Sel),
        .MD_Rd_data (MD_Rd_data),
        .MD_Busy    (MD_Busy),
        .MD_Done    (MD_Done),
        .MD_DivZero (MD_DivZero),
        .MD_HI      (MD_HI),
        .MD_LO      (MD_LO)
    );

    // Reference: plain 64-bit arithmetic; done_k is the cycle after E0 holding Done
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dz, output int done_k);
        longint sa, sb, q, r;
        logic [63:0] p;
        int n;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        n  = 32;
        p  = '0;
        case (op)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'b0, a} * {32'b0, b};
            default: p = '0;
        endcase
        hi = p[63:32];
        lo = p[31:0];
        if (op[1]) begin
            if (b == 0) begin
                dz = 1'b1;
                hi = a;
                lo = 32'hFFFF_FFFF;
            end else if (op == 2'b10) begin
                q  = sa / sb;
                r  = sa % sb;
                lo = q[31:0];
                hi = r[31:0];
            end else begin
                lo = a / b;
                hi = a % b;
            end
        end
`ifdef MD_EARLY_TERM_EN
        if (!op[1]) begin
            logic [31:0] mb;
            mb = (op == 2'b00 && b[31]) ? (32'd0 - b) : b;
            n  = 1;
            for (int i = 0; i < 32; i++) if (mb[i]) n = i + 1;
        end
`endif
        done_k = dz ? 2 : n + 2;
    endfunction

    // Issue one op from a negedge, then observe until Done (bounded)
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold);
        EX_MD_Op    = op;
        EX_Rs_data  = a;
        EX_Rt_data  = b;
        EX_MD_Start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) EX_MD_Start = 1'b0;
        o_done_k = 0; o_busy_cnt = 0; o_drift = 0; o_stray_dz = 0;
        o_busy_at_done = 1'b0; o_dz = 1'b0; o_hi = '0; o_lo = '0;
        for (int k = 1; k <= 100 && o_done_k == 0; k++) begin
            @(negedge clk);
            if (MD_Done) begin
                o_done_k       = k;
                o_dz           = MD_DivZero;
                o_hi           = MD_HI;
                o_lo           = MD_LO;
                o_busy_at_done = MD_Busy;
            end else begin
                if (MD_Busy) o_busy_cnt++;
                if (MD_DivZero) o_stray_dz++;
                if (MD_HI !== m_hi || MD_LO !== m_lo ||
                    MD_Rd_data !== (EX_MD_Sel ? m_hi : m_lo)) o_drift++;
                if (hold) begin
                    EX_Rs_data = $urandom;
                    EX_Rt_data = $urandom;
                    EX_MD_Op   = 2'($urandom);
                end
                EX_MD_Sel = 1'($urandom);
            end
        end
        EX_MD_Start = 1'b0;
        EX_MD_Sel   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 5;
        if (MD_Busy !== 1'b0)    begin n_errors++; $display("FAIL reset_busy: got %b exp 0", MD_Busy); end
        if (MD_Done !== 1'b0)    begin n_errors++; $display("FAIL reset_done: got %b exp 0", MD_Done); end
        if (MD_DivZero !== 1'b0) begin n_errors++; $display("FAIL reset_dz: got %b exp 0", MD_DivZero); end
        if (MD_HI !== 32'h0)     begin n_errors++; $display("FAIL reset_hi: got %h exp 0", MD_HI); end
        if (MD_LO !== 32'h0)     begin n_errors++; $display("FAIL reset_lo: got %h exp 0", MD_LO); end
        rst = 1'b1;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
    endtask

    // Spec vectors issued back to back; HI/LO literals are independent of the model
    task automatic test_directed();
        logic [1:0]  ops [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b01};
        logic [31:0] as  [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd5, 32'd3};
        logic [31:0] bs  [7] = '{32'd7, 32'hFFFFFFFF, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd0, 32'd5};
        logic [31:0] his [7] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd5, 32'd0};
        logic [31:0] los [7] = '{32'hFFFFFFEB, 32'h1, 32'hFFFFFFFD, 32'd3, 32'h80000000, 32'hFFFFFFFF, 32'd15};
        logic [31:0] e_hi, e_lo;
        logic        e_dz;
        int          e_k;
        for (int i = 0; i < 7; i++) begin
            model(ops[i], as[i], bs[i], e_hi, e_lo, e_dz, e_k);
            run_op(ops[i], as[i], bs[i], 1'b0);
            n_checks += 8;
            if (o_hi !== his[i]) begin n_errors++; $display("FAIL dir%0d_hi: got %h exp %h", i, o_hi, his[i]); end
            if (o_lo !== los[i]) begin n_errors++; $display("FAIL dir%0d_lo: got %h exp %h", i, o_lo, los[i]); end
            if (o_dz !== e_dz)   begin n_errors++; $display("FAIL dir%0d_dz: got %b exp %b", i, o_dz, e_dz); end
            if (o_done_k != e_k) begin n_errors++; $display("FAIL dir%0d_done_cycle: got %0d exp %0d", i, o_done_k, e_k); end
            if (o_busy_cnt != e_k - 1) begin n_errors++; $display("FAIL dir%0d_busy_cycles: got %0d exp %0d", i, o_busy_cnt, e_k - 1); end
            if (o_busy_at_done !== 1'b0) begin n_errors++; $display("FAIL dir%0d_busy_at_done: got %b exp 0", i, o_busy_at_done); end
            if (o_drift != 0)    begin n_errors++; $display("FAIL dir%0d_hilo_while_busy: got %0d changes exp 0", i, o_drift); end
            if (o_stray_dz != 0) begin n_errors++; $display("FAIL dir%0d_stray_dz: got %0d exp 0", i, o_stray_dz); end
            m_hi = his[i];
            m_lo = los[i];
        end
    endtask

    task automatic test_mfhi();
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        m_hi = 32'hFFFFFFFE;
        m_lo = 32'h1;
        EX_MD_Sel = 1'b1;
        #1;
        n_checks++;
        if (MD_Rd_data !== 32'hFFFFFFFE) begin n_errors++; $display("FAIL mfhi: got %h exp fffffffe", MD_Rd_data); end
        EX_MD_Sel = 1'b0;
        #1;
        n_checks++;
        if (MD_Rd_data !== 32'h1) begin n_errors++; $display("FAIL mflo: got %h exp 00000001", MD_Rd_data); end
        @(negedge clk);
    endtask

    task automatic test_busy_start();
        logic [31:0] e_hi, e_lo;
        logic        e_dz;
        int          e_k, extra;
        model(2'b10, 32'hFFFF_FF9C, 32'd7, e_hi, e_lo, e_dz, e_k);
        run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 1'b1);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (MD_Done) extra++;
        end
        n_checks += 4;
        if (o_hi !== e_hi)   begin n_errors++; $display("FAIL held_start_hi: got %h exp %h", o_hi, e_hi); end
        if (o_lo !== e_lo)   begin n_errors++; $display("FAIL held_start_lo: got %h exp %h", o_lo, e_lo); end
        if (o_done_k != e_k) begin n_errors++; $display("FAIL held_start_done_cycle: got %0d exp %0d", o_done_k, e_k); end
        if (extra != 0)      begin n_errors++; $display("FAIL held_start_extra_done: got %0d exp 0", extra); end
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    task automatic test_reset_midop();
        int dones;
        EX_MD_Op    = 2'b01;
        EX_Rs_data  = $urandom;
        EX_Rt_data  = 32'hFFFFFFFF;
        EX_MD_Start = 1'b1;
        @(posedge clk);
        #1 EX_MD_Start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks += 4;
        if (MD_Busy !== 1'b0) begin n_errors++; $display("FAIL midop_rst_busy: got %b exp 0", MD_Busy); end
        if (MD_Done !== 1'b0) begin n_errors++; $display("FAIL midop_rst_done: got %b exp 0", MD_Done); end
        if (MD_HI !== 32'h0)  begin n_errors++; $display("FAIL midop_rst_hi: got %h exp 0", MD_HI); end
        if (MD_LO !== 32'h0)  begin n_errors++; $display("FAIL midop_rst_lo: got %h exp 0", MD_LO); end
        rst  = 1'b1;
        m_hi = '0;
        m_lo = '0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (MD_Done) dones++;
        end
        n_checks++;
        if (dones != 0) begin n_errors++; $display("FAIL midop_rst_late_done: got %0d exp 0", dones); end
    endtask

    // Second op is started in the Done cycle of the first
    task automatic test_back_to_back();
        logic [31:0] e_hi, e_lo;
        logic        e_dz;
        int          e_k;
        run_op(2'b11, 32'd100, 32'd9, 1'b0);
        n_checks += 2;
        if (o_lo !== 32'd11) begin n_errors++; $display("FAIL b2b_first_lo: got %h exp 0000000b", o_lo); end
        if (o_hi !== 32'd1)  begin n_errors++; $display("FAIL b2b_first_hi: got %h exp 00000001", o_hi); end
        m_hi = 32'd1;
        m_lo = 32'd11;
        model(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, e_hi, e_lo, e_dz, e_k);
        run_op(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        n_checks += 3;
        if (o_lo !== 32'd6)  begin n_errors++; $display("FAIL b2b_second_lo: got %h exp 00000006", o_lo); end
        if (o_hi !== 32'd0)  begin n_errors++; $display("FAIL b2b_second_hi: got %h exp 00000000", o_hi); end
        if (o_done_k != e_k) begin n_errors++; $display("FAIL b2b_second_done_cycle: got %0d exp %0d", o_done_k, e_k); end
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, e_hi, e_lo;
        logic        e_dz;
        int          e_k;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(0, 255);
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            model(op, a, b, e_hi, e_lo, e_dz, e_k);
            run_op(op, a, b, 1'b0);
            n_checks += 5;
            if (o_hi !== e_hi)   begin n_errors++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h exp %h", i, op, a, b, o_hi, e_hi); end
            if (o_lo !== e_lo)   begin n_errors++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h exp %h", i, op, a, b, o_lo, e_lo); end
            if (o_dz !== e_dz)   begin n_errors++; $display("FAIL rnd%0d_dz: got %b exp %b", i, o_dz, e_dz); end
            if (o_done_k != e_k) begin n_errors++; $display("FAIL rnd%0d_done_cycle: got %0d exp %0d", i, o_done_k, e_k); end
            if (o_drift != 0)    begin n_errors++; $display("FAIL rnd%0d_hilo_while_busy: got %0d changes exp 0", i, o_drift); end
            m_hi = e_hi;
            m_lo = e_lo;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mfhi();
        test_reset_midop();
        test_busy_start();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
